// File: rtl/i2c_master.sv
// i2c_master: single-byte LSB-first I2C bus master (START, addr+rw, ACK, data, ACK, STOP).
// Define I2C_MASTER_ACK_CHECK_EN to abort to STOP when the address phase is NACKed.
module i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl,
  inout  wire        sda
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    abyte_q, abyte_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic          nack_q, nack_d, rsp_valid_q, rsp_valid_d;
  logic          div_end, slot_end, sample, skip, sda_low;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      qtr_q       <= '0;
      bit_q       <= '0;
      abyte_q     <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      nack_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      abyte_q     <= abyte_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      nack_q      <= nack_d;
      rsp_valid_q <= rsp_valid_d;
    end
  always_comb begin
    div_end  = div_q == DW'(CLK_DIV - 1);
    slot_end = div_end && qtr_q == 2'd3;
    sample   = div_end && qtr_q == 2'd2;
`ifdef I2C_MASTER_ACK_CHECK_EN
    skip     = nack_q;
`else
    skip     = 1'b0;
`endif
    state_d     = state_q;
    div_d       = (state_q == IDLE || div_end) ? '0 : div_q + DW'(1);
    qtr_d       = state_q == IDLE ? 2'd0 : qtr_q + 2'(div_end);
    bit_d       = bit_q;
    abyte_d     = abyte_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    nack_d      = nack_q;
    rsp_valid_d = 1'b0;
    if (state_q == IDLE && cmd_valid) begin
      state_d = START;
      abyte_d = {cmd_wr, cmd_addr};
      wdata_d = cmd_wdata;
      nack_d  = 1'b0;
    end
    // abyte_q[7] is the direction bit: ACK2 is only the slave's on writes
    if (sample && (state_q == ACK1 || (state_q == ACK2 && abyte_q[7])))
      nack_d = nack_q | sda;
    if (sample && state_q == DATA && !abyte_q[7])
      rdata_d[bit_q] = sda;
    if (slot_end) begin
      state_d = state_q == START ? ADDR :
                state_q == ADDR  ? (bit_q == 3'd7 ? ACK1 : ADDR) :
                state_q == ACK1  ? (skip ? STOP : DATA) :
                state_q == DATA  ? (bit_q == 3'd7 ? ACK2 : DATA) :
                state_q == ACK2  ? STOP : IDLE;
      bit_d       = (state_q == ADDR || state_q == DATA) ? bit_q + 3'd1 : 3'd0;
      rsp_valid_d = state_q == STOP;
    end
  end
  always_comb begin
    cmd_ready = state_q == IDLE;
    busy      = state_q != IDLE;
    scl       = (state_q == IDLE || state_q == START) ? 1'b1 : qtr_q[1];
    sda_low   = state_q == START ? qtr_q[1] :
                state_q == ADDR  ? !abyte_q[bit_q] :
                state_q == DATA  ? abyte_q[7] && !wdata_q[bit_q] :
                state_q == STOP  ? qtr_q != 2'd3 : 1'b0;
    rsp_valid = rsp_valid_q;
    rsp_rdata = rdata_q;
    rsp_nack  = nack_q;
  end
  assign sda = sda_low ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed bench for i2c_master with a small open-drain slave model on each bus.
module tb_i2c_master;
`ifdef I2C_MASTER_ACK_CHECK_EN
  localparam int NACK_LEN = 176;
`else
  localparam int NACK_LEN = 320;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_wr = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_nack, busy, scl;
  logic [7:0] rsp_rdata;
  wire sda0;
  logic slave_low = 1'b0;
  logic v1 = 1'b0, w1 = 1'b0;
  logic [6:0] a1 = '0;
  logic [7:0] d1 = '0;
  logic r1_ready, r1_valid, r1_nack, busy1, scl1;
  logic [7:0] r1_rdata;
  wire sda1;
  logic slave1_low = 1'b0;
  int vec = 0, miss = 0;
  logic s_ack1 = 1'b1, s_wr = 1'b1;
  logic [7:0] s_rd = '0;
  logic cap [0:31];
  logic cap1 [0:31];
  int nrise = 0, nfall = 0, nrise1 = 0, nfall1 = 0;
  time tr1 [0:1];

  always #5 clk = ~clk;
  pullup (sda0);
  pullup (sda1);
  assign sda0 = slave_low ? 1'b0 : 1'bz;
  assign sda1 = slave1_low ? 1'b0 : 1'bz;

  i2c_master #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_wr(cmd_wr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
    .busy(busy), .scl(scl), .sda(sda0));

  i2c_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v1), .cmd_ready(r1_ready),
    .cmd_addr(a1), .cmd_wr(w1), .cmd_wdata(d1),
    .rsp_valid(r1_valid), .rsp_rdata(r1_rdata), .rsp_nack(r1_nack),
    .busy(busy1), .scl(scl1), .sda(sda1));

  // Slave model: slot k begins at the k-th scl fall after busy rises
  // (1..8 address, 9 ACK1, 10..17 data, 18 ACK2, 19 STOP).
  always @(posedge busy) begin nrise = 0; nfall = 0; slave_low = 1'b0; end
  always @(posedge scl) if (busy) begin
    if (nrise < 32) cap[nrise] = sda0;
    nrise++;
  end
  always @(negedge scl) if (busy) begin
    nfall++;
    slave_low = nfall == 9 ? s_ack1 :
                (nfall >= 10 && nfall <= 17) ? (!s_wr && !s_rd[nfall-10]) :
                nfall == 18 ? s_wr : 1'b0;
  end
  always @(posedge busy1) begin nrise1 = 0; nfall1 = 0; slave1_low = 1'b0; end
  always @(posedge scl1) if (busy1) begin
    if (nrise1 < 2) tr1[nrise1] = $time;
    if (nrise1 < 32) cap1[nrise1] = sda1;
    nrise1++;
  end
  always @(negedge scl1) if (busy1) begin
    nfall1++;
    slave1_low = nfall1 == 9 || nfall1 == 18;
  end

  function automatic logic [7:0] cap_byte(input int base);
    for (int i = 0; i < 8; i++) cap_byte[i] = cap[base + i];
  endfunction
  function automatic logic [7:0] cap1_byte(input int base);
    for (int i = 0; i < 8; i++) cap1_byte[i] = cap1[base + i];
  endfunction

  task automatic run0(input logic [6:0] a, input logic w, input logic [7:0] d,
                      input logic ack1, input logic [7:0] srd, output int n);
    s_ack1 = ack1; s_wr = w; s_rd = srd;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_wr = w; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = ~a; cmd_wr = ~w; cmd_wdata = ~d;
    n = 0;
    while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    #22;
    vec++; if ({scl, sda0, busy, cmd_ready, rsp_valid, rsp_nack} !== 6'b110100) begin miss++; $display("FAIL reset_ctl: got %b want 110100", {scl, sda0, busy, cmd_ready, rsp_valid, rsp_nack}); end
    vec++; if (rsp_rdata !== 8'h00) begin miss++; $display("FAIL reset_rdata: got %h want 00", rsp_rdata); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_write();
    int n;
    run0(7'h2A, 1'b1, 8'hC3, 1'b1, 8'h00, n);
    vec++; if (n !== 320) begin miss++; $display("FAIL write_len: got %0d want 320", n); end
    vec++; if (cap_byte(0) !== 8'hAA) begin miss++; $display("FAIL write_addr_bits: got %h want aa", cap_byte(0)); end
    vec++; if (cap_byte(9) !== 8'hC3) begin miss++; $display("FAIL write_data_bits: got %h want c3", cap_byte(9)); end
    vec++; if ({cap[8], cap[17]} !== 2'b00) begin miss++; $display("FAIL write_acks: got %b want 00", {cap[8], cap[17]}); end
    vec++; if ({rsp_nack, cmd_ready, busy} !== 3'b010) begin miss++; $display("FAIL write_rsp: got %b want 010", {rsp_nack, cmd_ready, busy}); end
    @(negedge clk);
    vec++; if (rsp_valid !== 1'b0) begin miss++; $display("FAIL write_pulse: got %b want 0", rsp_valid); end
  endtask

  task automatic test_read();
    int n;
    run0(7'h15, 1'b0, 8'h00, 1'b1, 8'h5A, n);
    vec++; if (n !== 320) begin miss++; $display("FAIL read_len: got %0d want 320", n); end
    vec++; if (cap_byte(0) !== 8'h15) begin miss++; $display("FAIL read_addr_bits: got %h want 15", cap_byte(0)); end
    vec++; if (rsp_rdata !== 8'h5A) begin miss++; $display("FAIL read_rdata: got %h want 5a", rsp_rdata); end
    vec++; if (cap[17] !== 1'b1) begin miss++; $display("FAIL read_ack2_released: got %b want 1", cap[17]); end
    vec++; if (rsp_nack !== 1'b0) begin miss++; $display("FAIL read_nack: got %b want 0", rsp_nack); end
  endtask

  task automatic test_nack();
    int n;
    run0(7'h40, 1'b1, 8'h99, 1'b0, 8'h00, n);
    vec++; if (n !== NACK_LEN) begin miss++; $display("FAIL nack_len: got %0d want %0d", n, NACK_LEN); end
    vec++; if (rsp_nack !== 1'b1) begin miss++; $display("FAIL nack_flag: got %b want 1", rsp_nack); end
    vec++; if (rsp_rdata !== 8'h5A) begin miss++; $display("FAIL nack_rdata_hold: got %h want 5a", rsp_rdata); end
  endtask

  task automatic test_mid_reset();
    int n;
    s_ack1 = 1'b1; s_wr = 1'b1;
    @(negedge clk); cmd_valid = 1'b1; cmd_addr = 7'h11; cmd_wr = 1'b1; cmd_wdata = 8'h00;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (170) @(negedge clk);
    vec++; if (busy !== 1'b1) begin miss++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    vec++; if ({scl, sda0, busy, cmd_ready, rsp_valid} !== 5'b11010) begin miss++; $display("FAIL midrst_ctl: got %b want 11010", {scl, sda0, busy, cmd_ready, rsp_valid}); end
    @(negedge clk); rst_n = 1'b1;
    run0(7'h3C, 1'b1, 8'h81, 1'b1, 8'h00, n);
    vec++; if (n !== 320) begin miss++; $display("FAIL midrst_len: got %0d want 320", n); end
    vec++; if ({cap_byte(0), cap_byte(9)} !== 16'hBC81) begin miss++; $display("FAIL midrst_bits: got %h want bc81", {cap_byte(0), cap_byte(9)}); end
    vec++; if ({rsp_nack, rsp_rdata} !== 9'h000) begin miss++; $display("FAIL midrst_rsp: got %h want 000", {rsp_nack, rsp_rdata}); end
  endtask

  task automatic test_back_to_back();
    int n;
    s_ack1 = 1'b1; s_wr = 1'b1;
    @(negedge clk); cmd_valid = 1'b1; cmd_addr = 7'h0C; cmd_wr = 1'b1; cmd_wdata = 8'hA5;
    @(negedge clk);
    vec++; if ({busy, scl, sda0} !== 3'b111) begin miss++; $display("FAIL b2b_start: got %b want 111", {busy, scl, sda0}); end
    cmd_addr = 7'h33; cmd_wdata = 8'h0F;
    n = 0;
    while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
    vec++; if (n !== 320) begin miss++; $display("FAIL b2b_len1: got %0d want 320", n); end
    vec++; if ({cap_byte(0), cap_byte(9)} !== 16'h8CA5) begin miss++; $display("FAIL b2b_bits1: got %h want 8ca5", {cap_byte(0), cap_byte(9)}); end
    vec++; if (cmd_ready !== 1'b1) begin miss++; $display("FAIL b2b_ready: got %b want 1", cmd_ready); end
    @(negedge clk); cmd_valid = 1'b0;
    vec++; if ({busy, rsp_valid} !== 2'b10) begin miss++; $display("FAIL b2b_restart: got %b want 10", {busy, rsp_valid}); end
    n = 0;
    while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
    vec++; if (n !== 320) begin miss++; $display("FAIL b2b_len2: got %0d want 320", n); end
    vec++; if ({cap_byte(0), cap_byte(9)} !== 16'hB30F) begin miss++; $display("FAIL b2b_bits2: got %h want b30f", {cap_byte(0), cap_byte(9)}); end
    @(negedge clk);
    vec++; if ({busy, cmd_ready} !== 2'b01) begin miss++; $display("FAIL b2b_idle: got %b want 01", {busy, cmd_ready}); end
  endtask

  task automatic test_clk_div1();
    int n;
    @(negedge clk); v1 = 1'b1; a1 = 7'h7F; w1 = 1'b1; d1 = 8'hFF;
    @(negedge clk); v1 = 1'b0;
    n = 0;
    while (!r1_valid && n < 500) begin @(negedge clk); n++; end
    vec++; if (n !== 80) begin miss++; $display("FAIL div1_len: got %0d want 80", n); end
    vec++; if ({cap1_byte(0), cap1_byte(9)} !== 16'hFFFF) begin miss++; $display("FAIL div1_bits: got %h want ffff", {cap1_byte(0), cap1_byte(9)}); end
    vec++; if (tr1[1] - tr1[0] !== 40) begin miss++; $display("FAIL div1_scl_period: got %0t want 40", tr1[1] - tr1[0]); end
    vec++; if (r1_nack !== 1'b0) begin miss++; $display("FAIL div1_nack: got %b want 0", r1_nack); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_mid_reset();
    test_back_to_back();
    test_clk_div1();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
